// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, field constants and GF(2^8) helpers
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t AES_POLY     = 8'h1B;
  localparam byte_t AFFINE_C     = 8'h63;
  localparam byte_t INV_AFFINE_C = 8'h05;

  // Left rotate of one byte by a fixed amount
  function automatic byte_t rotl(input byte_t b, input int unsigned n);
    return byte_t'((b << n) | (b >> (8 - n)));
  endfunction

  // GF(2^8) multiply, shift-and-add with reduction by x^8+x^4+x^3+x+1
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ AES_POLY) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254; the chain yields 0 for b=0 as required
  function automatic byte_t gf_inv(input byte_t b);
    byte_t r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), b);
    end
    return gf_mul(r, r);
  endfunction

endpackage

// File: rtl/sbox_byte.sv
// rtl/sbox_byte.sv - combinational forward/inverse AES S-box for one byte
module sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);

  byte_t w_inv_affine;
  byte_t w_gf_src;
  byte_t w_gf_out;
  byte_t w_fwd_affine;

  // Inverse affine step runs ahead of the shared inverter on the decrypt path
  assign w_inv_affine = rotl(i_byte, 1) ^ rotl(i_byte, 3) ^ rotl(i_byte, 6) ^ INV_AFFINE_C;

  // One GF inverter serves both directions; only its input source changes
  assign w_gf_src = i_inv ? w_inv_affine : i_byte;
  assign w_gf_out = gf_inv(w_gf_src);

  // Forward affine step follows the inverter on the encrypt path
  assign w_fwd_affine = w_gf_out ^ rotl(w_gf_out, 1) ^ rotl(w_gf_out, 2)
                      ^ rotl(w_gf_out, 3) ^ rotl(w_gf_out, 4) ^ AFFINE_C;

  assign o_byte = i_inv ? w_gf_out : w_fwd_affine;

endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - 16-lane registered SubBytes / InvSubBytes stage
module sub_bytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] istate,
  output logic         out_valid,
  output logic [127:0] ostate
);

  state_t w_sub;
  state_t r_ostate;
  logic   r_valid;

  // Each lane substitutes its own byte; positions are never permuted
  for (genvar k = 0; k < 16; k++) begin : g_lane
    sbox_byte u_sbox (
      .i_byte (istate[8*k +: 8]),
      .i_inv  (inv),
      .o_byte (w_sub[8*k +: 8])
    );
  end

  // Output register: loads on valid, holds otherwise; reset wins over valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ostate <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_ostate <= w_sub;
    end
  end

  assign ostate    = r_ostate;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_sub_bytes.sv
// tb/tb_sub_bytes.sv - scoreboard bench for sub_bytes against the FIPS-197 tables
module tb_sub_bytes;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inv;
  logic [127:0] istate;
  logic         out_valid;
  logic [127:0] ostate;

  int tests_run;
  int tests_failed;
  int sb_idx;

  logic [127:0] exp_q[$];
  logic [127:0] last_exp;

  logic [0:255][7:0] sbox_tbl;
  logic [7:0]        isbox_tbl [256];

  sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inv       (inv),
    .istate    (istate),
    .out_valid (out_valid),
    .ostate    (ostate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] model(input logic [127:0] x, input logic iv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = iv ? isbox_tbl[x[8*k +: 8]] : sbox_tbl[x[8*k +: 8]];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [127:0] st, input logic iv, input logic [127:0] exp);
    in_valid = 1'b1;
    istate   = st;
    inv      = iv;
    exp_q.push_back(exp);
    last_exp = exp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    istate   = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expected value for every cycle the DUT presents a result
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_valid: out_valid=1 with no pending transfer, ostate %h", ostate);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        tests_run++;
        if (ostate !== e) begin
          tests_failed++;
          $display("FAIL scoreboard#%0d: got %h expected %h", sb_idx, ostate, e);
        end
        sb_idx++;
      end
    end
  end

  initial begin
    logic [127:0] x;
    logic [127:0] y;
    tests_run    = 0;
    tests_failed = 0;
    sb_idx       = 0;
    last_exp     = '0;
    sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) isbox_tbl[sbox_tbl[i]] = 8'(i);

    rst_n    = 1'b0;
    in_valid = 1'b0;
    inv      = 1'b0;
    istate   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ostate", ostate, 128'h0);
    check("reset_valid", {127'h0, out_valid}, 128'h0);
    rst_n = 1'b1;
    idle();

    // Byte-fill vectors with hand-known S-box values, inv toggling
    issue({16{8'h00}}, 1'b0, {16{8'h63}});
    issue({16{8'h63}}, 1'b1, {16{8'h00}});
    issue({16{8'h53}}, 1'b0, {16{8'hed}});
    issue({16{8'hed}}, 1'b1, {16{8'h53}});
    issue({16{8'hff}}, 1'b0, {16{8'h16}});
    issue({16{8'h16}}, 1'b1, {16{8'hff}});
    issue({16{8'h01}}, 1'b0, {16{8'h7c}});
    issue({16{8'h7c}}, 1'b1, {16{8'h01}});
    idle();
    check("idle_valid", {127'h0, out_valid}, 128'h0);
    check("idle_hold", ostate, last_exp);

    // FIPS-197 round vector, both directions
    issue(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230);
    issue(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    idle();

    // Round trip of a directed state then random states
    x = 128'h1323456789abcdef0123456789abcdef;
    y = model(x, 1'b0);
    issue(x, 1'b0, y);
    issue(y, 1'b1, x);
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = model(x, 1'b0);
      issue(x, 1'b0, y);
      issue(y, 1'b1, x);
    end
    idle();
    check("hold_after_random", ostate, last_exp);

    // Exhaustive: each lane sees every byte value in both directions
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 16; k++) x[8*k +: 8] = 8'(v + 17 * k);
      issue(x, 1'b0, model(x, 1'b0));
      issue(x, 1'b1, model(x, 1'b1));
    end
    idle();
    check("idle_valid_2", {127'h0, out_valid}, 128'h0);
    check("hold_after_exhaustive", ostate, last_exp);

    // Reset coincident with a valid transfer: reset must win
    rst_n    = 1'b0;
    in_valid = 1'b1;
    inv      = 1'b0;
    istate   = {16{8'h53}};
    @(posedge clk);
    #1;
    check("rst_vs_valid_ostate", ostate, 128'h0);
    check("rst_vs_valid_valid", {127'h0, out_valid}, 128'h0);
    rst_n = 1'b1;
    issue({16{8'h53}}, 1'b0, {16{8'hed}});
    check("post_reset_valid", {127'h0, out_valid}, 128'h1);
    check("post_reset_ostate", ostate, {16{8'hed}});
    idle();
    idle();

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sub_bytes.md
# sub_bytes

AES byte-substitution stage covering both directions: forward SubBytes (encryption round) and InvSubBytes (decryption round) of FIPS-197, selected per transfer. It applies the 8-bit S-box or inverse S-box independently to all 16 bytes of a 128-bit state and registers the result. The block sits between AddRoundKey and ShiftRows (or their inverses) in the AES core that feeds the SPI front end.

## Interface
- No parameters; the state width is fixed at 128 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- in_valid  in  1  istate/inv are valid this cycle.
- inv  in  1  0 = forward SubBytes, 1 = InvSubBytes.
- istate  in  128  input state.
- out_valid  out  1  ostate holds a result.
- ostate  out  128  substituted state.

## Operation
- Byte k (k = 0..15) is istate[8k+7:8k] and maps to ostate[8k+7:8k]. Byte positions are never permuted.
- Field arithmetic is over GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B). Multiplicative inverse of 0x00 is defined as 0x00.
- Forward path: s = inv(b), then the affine step s ^ rotl(s,1) ^ rotl(s,2) ^ rotl(s,3) ^ rotl(s,4) ^ 0x63.
- Inverse path: t = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 0x05, then inv(t).
- Both paths must match the FIPS-197 tables exactly. Examples: S(00)=63, S(01)=7C, S(53)=ED, S(FF)=16; InvS(63)=00, InvS(7C)=01, InvS(16)=FF.
- Both paths are bijections, so InvSubBytes(SubBytes(x)) = x and SubBytes(InvSubBytes(x)) = x for every 128-bit x.
- An implementation may use a computed GF inverse or ROM tables, provided the results are identical.

## Timing
- Latency is 1 cycle. When in_valid=1 at edge N, ostate = f(istate, inv) and out_valid=1 after edge N.
- When in_valid=0 at an edge, out_valid goes to 0 and ostate holds its previous value.
- Throughput is one state per cycle. Back-to-back transfers are supported, and inv may change on every transfer.
- Reset: when rst_n=0 at an edge, ostate=128'h0 and out_valid=0 regardless of in_valid. Reset takes priority over a simultaneous in_valid.
- No handshake or backpressure exists; downstream logic must consume the output on the cycle out_valid=1.
- The combinational path from istate to the output register must close timing at the core clock.

## Structure
- Shared package aes_pkg holds:
  - typedef state_t (128 bits) and byte_t (8 bits);
  - constants AES_POLY=8'h1B, AFFINE_C=8'h63, INV_AFFINE_C=8'h05.
- One sub-module, sbox_byte (inputs: 8-bit byte, inv; output: 8-bit byte; purely combinational), is instantiated 16 times.
- The top level holds only the 16 instances plus the output and valid registers.

## Test plan
- Byte vectors: fill all bytes with one value and cycle inv; check S(00)=63, S(53)=ED, S(FF)=16, InvS(63)=00, InvS(ED)=53.
- FIPS-197 round vector: istate=193de3bea0f4e22b9ac68d2ae9f84808, inv=0 -> ostate=d42711aee0bf98f1b8b45de51e415230 one cycle later. The same output word fed with inv=1 -> the original input.
- Round trip: istate=1323456789abcdef0123456789abcdef forward, then feed the result back with inv=1 -> ostate equals the original value. Repeat for 1000 random states.
- Exhaustive: all 256 byte values in every lane, both directions, compared against the FIPS-197 table model.
- Back-to-back transfers with alternating inv, followed by an idle cycle -> correct results each cycle, out_valid drops and ostate holds.
- Reset asserted in the same cycle as in_valid=1 -> ostate=0, out_valid=0. Normal operation resumes on the cycle after rst_n returns to 1.
